// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and load/store.
// Data has priority; a bounded run counter forces a fetch grant after MAX_DATA_RUN data wins.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int MEM_WORDS    = 512,
   parameter int MAX_DATA_RUN = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                RUN_W     = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_DATA_RUN);
   localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < MEM_LIMIT);
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [RUN_W-1:0]  run_cnt_r;
   logic              win_data_r;
   logic              lat_we_r;
   logic              lat_inr_r;
   logic [ADDR_W-1:0] lat_addr_r;
   logic [DATA_W-1:0] lat_wdata_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;
   logic              if_ack_r;
   logic              d_ack_r;
   logic              err_r;
   logic              grant_d_s;
   logic              grant_f_s;
   logic [DATA_W-1:0] cap_data_s;

   // Arbitration; requests are only looked at in IDLE, so a req still high in RESP is ignored.
   always_comb begin
      grant_d_s = 1'b0;
      grant_f_s = 1'b0;
      if (state_r == IDLE) begin
         if (d_req && (!if_req || (run_cnt_r != RUN_MAX))) begin
            grant_d_s = 1'b1;
         end else if (if_req) begin
            grant_f_s = 1'b1;
         end else begin
            grant_d_s = 1'b0;
            grant_f_s = 1'b0;
         end
      end else begin
         grant_d_s = 1'b0;
         grant_f_s = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = (grant_d_s || grant_f_s) ? ACCESS : IDLE;
         ACCESS:  state_next_s = RESP;
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Writes and out-of-range accesses return zero
   always_comb begin
      cap_data_s = {DATA_W{1'b0}};
      if (lat_we_r || !lat_inr_r) begin
         cap_data_s = {DATA_W{1'b0}};
      end else begin
         cap_data_s = mem_rdata;
      end
   end

   // Grant latching, run counter and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt_r   <= {RUN_W{1'b0}};
         win_data_r  <= 1'b0;
         lat_we_r    <= 1'b0;
         lat_inr_r   <= 1'b0;
         lat_addr_r  <= {ADDR_W{1'b0}};
         lat_wdata_r <= {DATA_W{1'b0}};
         if_rdata_r  <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
         if_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if_ack_r <= 1'b0;
         d_ack_r  <= 1'b0;
         err_r    <= 1'b0;
         if (grant_d_s) begin
            win_data_r  <= 1'b1;
            lat_addr_r  <= d_addr;
            lat_we_r    <= d_we;
            lat_wdata_r <= d_wdata;
            lat_inr_r   <= in_range(d_addr);
            if (if_req) begin
               run_cnt_r <= (run_cnt_r == RUN_MAX) ? RUN_MAX : run_cnt_r + RUN_W'(1);
            end else begin
               run_cnt_r <= {RUN_W{1'b0}};
            end
         end else if (grant_f_s) begin
            win_data_r  <= 1'b0;
            lat_addr_r  <= if_addr;
            lat_we_r    <= 1'b0;
            lat_wdata_r <= d_wdata;
            lat_inr_r   <= in_range(if_addr);
            run_cnt_r   <= {RUN_W{1'b0}};
         end else if (state_r == ACCESS) begin
            if (win_data_r) begin
               d_rdata_r <= cap_data_s;
               d_ack_r   <= 1'b1;
            end else begin
               if_rdata_r <= cap_data_s;
               if_ack_r   <= 1'b1;
            end
            err_r <= !lat_inr_r;
         end
      end
   end

   // FSM-decoded outputs; the RAM write strobe exists only during ACCESS
   always_comb begin
      mem_we = (state_r == ACCESS) && lat_we_r && lat_inr_r;
      busy   = (state_r == ACCESS) || (state_r == RESP);
   end

   assign mem_addr  = lat_addr_r;
   assign mem_wdata = lat_wdata_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign if_ack    = if_ack_r;
   assign d_ack     = d_ack_r;
   assign err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level timing/priority model plus
// shadow memory, driven by directed scenarios and randomized traffic.
module tb_mem_arbiter;

   localparam int AW     = 16;
   localparam int DW     = 16;
   localparam int WORDS  = 512;
   localparam int MAXRUN = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_ack, d_req, d_we, d_ack, err, busy, mem_we;
   logic [AW-1:0] if_addr, d_addr, mem_addr;
   logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(WORDS), .MAX_DATA_RUN(MAXRUN)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .busy(busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM seen by the DUT
   logic [DW-1:0] ram [WORDS];
   assign mem_rdata = (mem_addr < AW'(WORDS)) ? ram[mem_addr[8:0]] : 16'hBAD0;
   always @(posedge clk) if (mem_we && (mem_addr < AW'(WORDS))) ram[mem_addr[8:0]] <= mem_wdata;

   // Reference model state
   logic [DW-1:0] ref_mem [WORDS];
   int            edge_cnt = 0, next_grant = 0, grant_edge = 0, streak = 0;
   bit            active = 0, cur_is_d = 0, cur_we = 0;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic [DW-1:0] exp_rd_f = '0, exp_rd_d = '0;
   bit            exp_ack_f, exp_ack_d, exp_err, exp_we, exp_busy;

   // Requester state
   bit            f_pend = 0, f_gnt = 0, f_auto = 0;
   bit            d_pend = 0, d_gnt = 0, d_auto = 0;
   logic [AW-1:0] f_addr = '0, d_addr_m = '0;
   logic          d_we_m = 1'b0;
   logic [DW-1:0] d_wdata_m = '0;
   string         order = "";

   int n_checks = 0, n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
   endtask

   function automatic bit in_rng(input logic [AW-1:0] a);
      return a < AW'(WORDS);
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom_range(WORDS, 65535));
      return AW'($urandom_range(0, 31));
   endfunction

   task automatic issue_f(input logic [AW-1:0] a);
      f_pend = 1; f_gnt = 0; f_addr = a;
   endtask

   task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      d_pend = 1; d_gnt = 0; d_we_m = we; d_addr_m = a; d_wdata_m = wd;
   endtask

   // One clock: drive inputs, predict the edge, sample #1 after it, react to acks
   task automatic step(input bit rst_in);
      bit chk_addr, g_d;
      chk_addr = 0;
      reset   = rst_in;
      if_req  = f_pend;
      if_addr = f_gnt ? AW'($urandom) : f_addr;
      d_req   = d_pend;
      d_we    = d_gnt ? 1'($urandom) : d_we_m;
      d_addr  = d_gnt ? AW'($urandom) : d_addr_m;
      d_wdata = d_gnt ? DW'($urandom) : d_wdata_m;
      exp_ack_f = 0; exp_ack_d = 0; exp_err = 0; exp_we = 0; exp_busy = 0;
      if (rst_in) begin
         if (active && edge_cnt == grant_edge + 1 && cur_we && in_rng(cur_addr))
            ref_mem[cur_addr[8:0]] = cur_wdata;
         active = 0; streak = 0; next_grant = edge_cnt + 1;
         exp_rd_f = '0; exp_rd_d = '0;
         f_pend = 0; f_gnt = 0; d_pend = 0; d_gnt = 0;
      end else if (active && edge_cnt == grant_edge + 1) begin
         if (cur_we && in_rng(cur_addr)) ref_mem[cur_addr[8:0]] = cur_wdata;
         if (cur_is_d) begin
            exp_ack_d = 1;
            exp_rd_d  = (cur_we || !in_rng(cur_addr)) ? '0 : ref_mem[cur_addr[8:0]];
         end else begin
            exp_ack_f = 1;
            exp_rd_f  = in_rng(cur_addr) ? ref_mem[cur_addr[8:0]] : '0;
         end
         exp_err = !in_rng(cur_addr);
         active = 0; next_grant = edge_cnt + 2; exp_busy = 1;
      end else if (!active && edge_cnt >= next_grant && (f_pend || d_pend)) begin
         g_d = d_pend && (!f_pend || streak < MAXRUN);
         if (g_d && f_pend) streak = streak + 1; else streak = 0;
         cur_is_d  = g_d;
         cur_addr  = g_d ? d_addr_m : f_addr;
         cur_we    = g_d ? d_we_m : 1'b0;
         cur_wdata = d_wdata_m;
         if (g_d) d_gnt = 1; else f_gnt = 1;
         exp_we = cur_we && in_rng(cur_addr);
         active = 1; grant_edge = edge_cnt; exp_busy = 1; chk_addr = 1;
      end
      @(posedge clk);
      #1;
      check_val("if_ack", 32'(if_ack), 32'(exp_ack_f));
      check_val("d_ack", 32'(d_ack), 32'(exp_ack_d));
      check_val("err", 32'(err), 32'(exp_err));
      check_val("busy", 32'(busy), 32'(exp_busy));
      check_val("mem_we", 32'(mem_we), 32'(exp_we));
      check_val("if_rdata", 32'(if_rdata), 32'(exp_rd_f));
      check_val("d_rdata", 32'(d_rdata), 32'(exp_rd_d));
      if (chk_addr) check_val("mem_addr", 32'(mem_addr), 32'(cur_addr));
      if (chk_addr && cur_is_d) check_val("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
      if (rst_in) begin
         check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
         check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      end
      if (if_ack) order = {order, "F"};
      if (d_ack)  order = {order, "D"};
      if (exp_ack_f) begin
         f_pend = 0; f_gnt = 0;
         if (f_auto) issue_f(rand_addr());
      end
      if (exp_ack_d) begin
         d_pend = 0; d_gnt = 0;
         if (d_auto) issue_d(1'($urandom), rand_addr(), DW'($urandom));
      end
      edge_cnt++;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (f_pend || d_pend || active); i++) step(1'b0);
      check_val("drain", 32'(f_pend || d_pend || active), 32'd0);
      step(1'b0);
   endtask

   initial begin
      logic [DW-1:0] v;
      for (int i = 0; i < WORDS; i++) begin
         v = DW'($urandom);
         ram[i] = v; ref_mem[i] = v;
      end
      ram[3] = 16'hC131; ref_mem[3] = 16'hC131;
      reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      step(1'b1);
      step(1'b1);
      step(1'b0);

      // Lone fetch
      issue_f(16'd3);
      step(1'b0);
      step(1'b0);
      check_val("fetch_data", 32'(if_rdata), 32'h0000C131);
      drain();

      // Store then load
      issue_d(1'b1, 16'd10, 16'h007B);
      drain();
      issue_d(1'b0, 16'd10, 16'h0000);
      drain();
      check_val("load_back", 32'(d_rdata), 32'h0000007B);

      // Out-of-range store and load
      issue_d(1'b1, 16'd512, 16'hFFFF);
      drain();
      issue_d(1'b0, 16'd600, 16'h0000);
      drain();
      check_val("oor_load", 32'(d_rdata), 32'd0);

      // Continuous contention
      order = "";
      f_auto = 1; d_auto = 1;
      issue_f(rand_addr());
      issue_d(1'($urandom), rand_addr(), DW'($urandom));
      for (int i = 0; i < 18; i++) step(1'b0);
      check_val("contention_order", 32'(order.substr(0, 5) == "DDFDDF"), 32'd1);
      f_auto = 0; d_auto = 0;
      drain();

      // Late data arrival during a fetch, fetch req held through RESP
      order = "";
      issue_f(16'd5);
      step(1'b0);
      issue_d(1'b0, 16'd7, 16'h0000);
      f_auto = 1;
      step(1'b0);
      f_auto = 0;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      check_val("late_order", 32'(order == "FD"), 32'd1);
      drain();

      // Reset on the closing edge of a store's ACCESS cycle
      issue_d(1'b1, 16'd20, 16'h5A5A);
      step(1'b0);
      step(1'b1);
      check_val("rst_store_commit", 32'(ram[20]), 32'h00005A5A);
      issue_f(16'd20);
      drain();
      check_val("post_rst_fetch", 32'(if_rdata), 32'h00005A5A);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if (!f_pend && $urandom_range(0, 2) == 0) issue_f(rand_addr());
         if (!d_pend && $urandom_range(0, 2) == 0) issue_d(1'($urandom), rand_addr(), DW'($urandom));
         step($urandom_range(0, 199) == 0);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data RAM between the instruction-fetch stage and the load/store (LW/SW) stage of the pipeline. Each requester uses a req/ack handshake. The arbiter grants one access at a time, drives the RAM address, write-enable and write-data, and returns registered read data. Data accesses have priority, and a bounded run counter guarantees fetch progress.

## Interface
- ADDR_W, 16, address width of both requesters and the RAM
- DATA_W, 16, data word width
- MEM_WORDS, 512, number of implemented RAM words; addresses >= MEM_WORDS are out of range
- MAX_DATA_RUN, 2, maximum consecutive data grants while fetch is pending (>= 1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetch read data; valid while if_ack
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store (SW), 0 = load (LW); stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack
- d_ack  out  1  one-cycle completion pulse for data
- err  out  1  pulses with the ack of an out-of-range access
- busy  out  1  high in ACCESS and RESP states
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- Reset values: all outputs 0, run_cnt 0, latched address/data/we 0, winner = fetch.
- **IDLE**: arbitrate on the sampled requests.
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant data unless run_cnt == MAX_DATA_RUN; in that case grant fetch.
  - On grant: latch winner, address, we (forced 0 for fetch), wdata, and the in-range flag (addr < MEM_WORDS). Go to ACCESS.
- run_cnt update at grant:
  - Fetch grant: run_cnt <= 0.
  - Data grant with if_req = 1: run_cnt <= min(run_cnt+1, MAX_DATA_RUN).
  - Data grant with if_req = 0: run_cnt <= 0.
- **ACCESS**:
  - mem_addr = latched address.
  - mem_wdata = latched wdata.
  - mem_we = latched we AND in-range.
  - At the closing edge:
    - Capture mem_rdata, or 0 if out of range or a write, into the winner's rdata register.
    - Set the winner's ack.
    - Set err = NOT in-range.
    - Go to RESP.
- **RESP**:
  - ack and err are high for this single cycle.
  - Requests are not sampled in RESP, because the acked requester's req is still high.
  - Next state is IDLE; ack and err clear.
- Outside ACCESS: mem_we = 0. mem_addr and mem_wdata hold their latched values.
- rdata registers hold their value after ack until the next completion for that requester.
- Out-of-range stores never assert mem_we. Out-of-range loads return 0 with err = 1.

## Timing
- Request high at edge E0 in IDLE: ACCESS during E0..E1, ack/err high during E1..E2, IDLE again at E2. The earliest next grant is at E3.
- Throughput is one access per 3 cycles.
- Requester may drop req at E2 (ack seen). The arbiter ignores req during RESP.
- A store commits to the RAM at E1.
- A request arriving while busy waits; there is no loss and no queue beyond the held req.
- Simultaneous requests are resolved only in IDLE, by the priority and run_cnt rule above.
- Reset mid-operation:
  - A store whose ACCESS closing edge coincides with reset high still commits, because mem_we is asserted during that cycle.
  - No ack is issued for it.
  - All state returns to reset values at that edge.
- Requester may change addr/we/wdata after grant; the latched copies are used.

## Test plan
- Lone fetch: mem[3] = 16'hC131, if_req with if_addr = 3 at E0 -> if_ack high only during E1..E2, if_rdata = 16'hC131, err = 0, busy high for 2 cycles.
- Store then load: d_req/d_we = 1, d_addr = 10, d_wdata = 16'h007B -> d_ack after 2 cycles. Then d_we = 0, d_addr = 10 -> d_rdata = 16'h007B.
- Continuous contention, MAX_DATA_RUN = 2, both reqs re-asserted immediately after each ack -> grant order D,D,F,D,D,F; fetch is never waiting for more than 3 grants.
- Out of range: d_we = 1, d_addr = 512 -> mem_we never asserted, d_ack and err pulse together. Load at 600 -> d_rdata = 0, err = 1.
- Reset during a store's ACCESS cycle -> RAM word written, no d_ack, outputs 0 next cycle, run_cnt = 0. A fresh fetch afterwards completes normally.
- Late arrival: d_req asserted during fetch's ACCESS -> fetch acks first, data is granted at E3, if_req is not re-granted while still high in RESP.
